jk_sequencer: RTL and testbench
===============================

# jk_sequencer

Command-driven controller for a bank of `WIDTH` JK flip-flops. It queues SET, CLEAR, TOGGLE and HOLD commands and drives the bank's shared `J`/`K` vectors cycle by cycle. It sits between a host and the `JKFLIPFLOP` instances, whose J/K inputs it owns exclusively. The instances' Q outputs stay external to this block.

## Interface
- `WIDTH`, default 4: number of JK flip-flops driven.
- `DEPTH`, default 4: command FIFO entries; must be a power of 2, ≥2.
- `CNT_W`, default 8: width of the cycle-count field.
- `CLK`  in  1: single clock; all state updates on its rising edge.
- `RST`  in  1: reset, synchronous and active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: FIFO can accept; transfer when `cmd_valid & cmd_ready` at a rising edge.
- `cmd_op`  in  2: 00 HOLD, 01 SET, 10 CLEAR, 11 TOGGLE.
- `cmd_mask`  in  WIDTH: flip-flops affected.
- `cmd_count`  in  CNT_W: HOLD/TOGGLE run length minus one; ignored for SET/CLEAR.
- `J`, `K`  out  WIDTH: registered drive to the flip-flop bank.
- `busy`  out  1: FSM not IDLE or FIFO non-empty.
- `done`  out  1: one-cycle pulse during the final drive cycle of each command.

## Operation
- Reset values:
  - `J`, `K`, `done`, `busy`: 0.
  - `cmd_ready`: 1.
  - FIFO: emptied.
  - FSM: IDLE.
  - Run counter: 0.
- `cmd_ready` = FIFO not full. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- Each command's drive per cycle:
  - SET: `J=mask`, `K=0` for 1 cycle.
  - CLEAR: `J=0`, `K=mask` for 1 cycle.
  - TOGGLE: `J=K=mask` for `count+1` cycles.
  - HOLD: `J=K=0` for `count+1` cycles.
- Run length: `count=0` gives 1 cycle and `count=2^CNT_W-1` gives 2^CNT_W cycles. Unsigned arithmetic; the counter counts down to 0 and never wraps.
- `mask=0` still consumes the full cycle count and pulses `done`.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop and load EXEC.
  - EXEC: drive J/K. Decrement the counter each cycle. On the final cycle, assert `done`, then either pop the next entry (stay in EXEC) or go to IDLE with `J=K=0`.
- Commands run back to back with no latch gap. Hosts that want a latch cycle between commands insert a HOLD with count 0.
- Whenever `J` and `K` are not being driven by a command, both are 0.
- Reset mid-command: at the next edge the FSM enters IDLE, `J=K=0`, the FIFO is flushed and `done` is not pulsed.

## Timing
- A command pushed at edge N into an empty FIFO while the FSM is IDLE is popped at edge N+1. Its first drive cycle is N+1→N+2, so the bank samples it at edge N+2.
- Input-to-first-drive latency is therefore 1 cycle.
- The next command's first drive cycle immediately follows the previous command's `done` cycle.
- `busy` falls in the first cycle after the last `done` if the FIFO is empty.
- `J`, `K`, `done` and `busy` are all registered. None has a combinational path from the inputs.

## Configuration
- `JKSEQ_SHADOW_EN`: compiles in the shadow model of Q.
- With the macro defined:
  - Adds output `q_shadow`, WIDTH bits. It resets to 0 and updates each edge by the JK rule from the current J/K.
  - Adds output `shadow_mismatch`, and input `q_in` (WIDTH). `shadow_mismatch` is registered and equals `q_in != q_shadow`.
- Without the macro, these ports and all associated logic are absent.

## Structure
- Package `jk_seq_pkg`:
  - `jk_op_e` enum: HOLD, SET, CLEAR, TOGGLE.
  - `jk_state_e` enum: IDLE, EXEC.
  - Packed struct `jk_cmd_t` with fields op, mask and count. Its width is derived from WIDTH/CNT_W through parameterized functions.
- One sub-module, `jk_cmd_fifo`: synchronous FIFO for `jk_cmd_t` with full/empty flags, DEPTH entries and synchronous reset.

## Test plan
- Hold `RST` high for 2 cycles → `J=K=0000`, `cmd_ready=1`, `busy=0`, `done=0`. With `RST` still high, a command pushed is discarded.
- SET mask 0101 → exactly 1 cycle of `J=0101`, `K=0000`, with `done` high in that cycle. Then `J=K=0`; `q_shadow=0101`.
- TOGGLE mask 0011 count 3, starting from shadow 0101 → 4 cycles of `J=K=0011`. Shadow goes 0110, 0101, 0110, 0101. One `done` pulse, in the 4th cycle.
- SET 1010 then CLEAR 1111 pushed on consecutive edges → consecutive drive cycles `J=1010/K=0000` then `J=0000/K=1111`, two `done` pulses and no gap.
- HOLD count 20 followed by 4 more pushes → `cmd_ready` low once 4 entries are held. A push while full is refused. The queued commands execute contiguously after the HOLD's 21st cycle.
- TOGGLE mask 1111 count 10, with `RST` asserted in the 3rd drive cycle → `J=K=0` from the next cycle, FIFO empty, no `done`, `busy=0`.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared types and sizing helpers for the JK flip-flop command sequencer.
// The command struct is declared at the widest supported size. Each
// instance stores only jk_cmd_bits(WIDTH, CNT_W) bits per FIFO entry.
package jk_seq_pkg;

   localparam int JK_MASK_MAX = 64;
   localparam int JK_CNT_MAX  = 32;

   typedef enum logic [1:0] {
      HOLD   = 2'b00,
      SET    = 2'b01,
      CLEAR  = 2'b10,
      TOGGLE = 2'b11
   } jk_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } jk_state_e;

   typedef struct packed {
      jk_op_e                 op;
      logic [JK_MASK_MAX-1:0] mask;
      logic [JK_CNT_MAX-1:0]  count;
   } jk_cmd_t;

   // Packed width of one stored command: op, then mask, then count
   function automatic int jk_cmd_bits(input int width, input int cnt_w);
      return $bits(jk_op_e) + width + cnt_w;
   endfunction

   function automatic int jk_ptr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/jk_sequencer_fifo.sv
// Command FIFO for the JK sequencer. DEPTH must be a power of two so the
// pointers wrap naturally. A push is refused whenever the FIFO is full,
// even if a pop happens in the same cycle.
module jk_cmd_fifo
   import jk_seq_pkg::*;
#(
   parameter int DATA_W = 14,
   parameter int DEPTH  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              empty_nxt
);

   localparam int AW = jk_ptr_bits(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              push_ok, pop_ok;

   assign full  = (cnt_q == FULL_CNT);
   assign empty = (cnt_q == '0);
   assign dout  = mem_q[rd_ptr_q];

   // Pointer and occupancy update for accepted pushes and pops
   always_comb begin
      push_ok   = push & ~full;
      pop_ok    = pop & ~empty;
      wr_ptr_d  = wr_ptr_q + AW'(push_ok);
      rd_ptr_d  = rd_ptr_q + AW'(pop_ok);
      cnt_d     = cnt_q + CW'(push_ok) - CW'(pop_ok);
      empty_nxt = (cnt_d == '0);
   end

   // Control registers; reset empties the FIFO
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage write; contents need no reset because the pointers gate them
   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/jk_sequencer.sv
// Command-driven J/K driver for a bank of WIDTH JK flip-flops.
// Optional macro JKSEQ_SHADOW_EN adds a shadow model of the bank's Q
// outputs (q_shadow) and a registered compare against q_in.
//
// state | meaning
// IDLE  | nothing executing; J=K=0; pops the FIFO head when one is present
// EXEC  | driving the current command; cnt_q holds the remaining cycles - 1
module jk_sequencer
   import jk_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_mask,
   input  logic [CNT_W-1:0] cmd_count,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic             busy,
   output logic             done
`ifdef JKSEQ_SHADOW_EN
   ,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] q_shadow,
   output logic             shadow_mismatch
`endif
);

   localparam int CMD_W = jk_cmd_bits(WIDTH, CNT_W);

   jk_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic             fifo_pop, fifo_full, fifo_empty, fifo_empty_nxt;
   logic [CMD_W-1:0] fifo_dout;
   jk_cmd_t          head;
   logic [WIDTH-1:0] head_mask;
   logic [CNT_W-1:0] head_count;

   jk_cmd_fifo #(
      .DATA_W (CMD_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (cmd_valid),
      .pop       (fifo_pop),
      .din       ({cmd_op, cmd_mask, cmd_count}),
      .dout      (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .empty_nxt (fifo_empty_nxt)
   );

   // Unpack the FIFO head into the command struct
   always_comb begin
      head.op    = jk_op_e'(fifo_dout[CMD_W-1 -: 2]);
      head.mask  = JK_MASK_MAX'(fifo_dout[CNT_W +: WIDTH]);
      head.count = JK_CNT_MAX'(fifo_dout[CNT_W-1:0]);
      head_mask  = head.mask[WIDTH-1:0];
      head_count = head.count[CNT_W-1:0];
   end

   // Next state, run counter and J/K drive; a pop loads the next command
   // directly so back-to-back commands leave no gap
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      j_d      = j_q;
      k_d      = k_q;
      done_d   = 1'b0;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: fifo_pop = ~fifo_empty;
         EXEC: begin
            if (cnt_q != '0) begin
               cnt_d  = cnt_q - CNT_W'(1);
               done_d = (cnt_q == CNT_W'(1));
            end else if (!fifo_empty) begin
               fifo_pop = 1'b1;
            end else begin
               state_d = IDLE;
               j_d     = '0;
               k_d     = '0;
            end
         end
         default: begin
            state_d = IDLE;
            j_d     = '0;
            k_d     = '0;
         end
      endcase
      if (fifo_pop) begin
         state_d = EXEC;
         cnt_d   = '0;
         case (head.op)
            SET: begin
               j_d = head_mask;
               k_d = '0;
            end
            CLEAR: begin
               j_d = '0;
               k_d = head_mask;
            end
            TOGGLE: begin
               j_d   = head_mask;
               k_d   = head_mask;
               cnt_d = head_count;
            end
            default: begin
               j_d   = '0;
               k_d   = '0;
               cnt_d = head_count;
            end
         endcase
         done_d = (cnt_d == '0);
      end
   end

   // Busy looks at post-edge state so it drops right after the last done
   assign busy_d = (state_d != IDLE) || !fifo_empty_nxt;

   // Sequencer registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         j_q     <= '0;
         k_q     <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         j_q     <= j_d;
         k_q     <= k_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign cmd_ready = ~fifo_full;
   assign J         = j_q;
   assign K         = k_q;
   assign done      = done_q;
   assign busy      = busy_q;

`ifdef JKSEQ_SHADOW_EN
   logic [WIDTH-1:0] q_shadow_q, q_shadow_d;
   logic             mismatch_q, mismatch_d;

   // Shadow Q follows the JK rule using the J/K currently being driven
   always_comb begin
      q_shadow_d = (j_q & ~q_shadow_q) | (~k_q & q_shadow_q);
      mismatch_d = (q_in != q_shadow_q);
   end

   // Shadow registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         q_shadow_q <= '0;
         mismatch_q <= 1'b0;
      end else begin
         q_shadow_q <= q_shadow_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign q_shadow        = q_shadow_q;
   assign shadow_mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_jk_sequencer.sv
// Bench for jk_sequencer: a stimulus process queues accepted commands with
// their acceptance cycle; a monitor derives each cycle's expected J/K/done/
// busy from those commands' run lengths and compares on the falling edge.
module tb_jk_sequencer;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   localparam int OP_HOLD   = 0;
   localparam int OP_SET    = 1;
   localparam int OP_CLEAR  = 2;
   localparam int OP_TOGGLE = 3;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = '0;
   logic [WIDTH-1:0] cmd_mask = '0;
   logic [CNT_W-1:0] cmd_count = '0;
   logic [WIDTH-1:0] J, K;
   logic             busy, done;
`ifdef JKSEQ_SHADOW_EN
   logic [WIDTH-1:0] q_in = '0;
   logic [WIDTH-1:0] q_shadow;
   logic             shadow_mismatch;
`endif

   jk_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_mask  (cmd_mask),
      .cmd_count (cmd_count),
      .J         (J),
      .K         (K),
      .busy      (busy),
      .done      (done)
`ifdef JKSEQ_SHADOW_EN
      ,
      .q_in            (q_in),
      .q_shadow        (q_shadow),
      .shadow_mismatch (shadow_mismatch)
`endif
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int               op;
      logic [WIDTH-1:0] mask;
      int               count;
      int               acc;
   } cmd_s;

   cmd_s             pending[$];
   cmd_s             cur;
   bit               active   = 1'b0;
   int               cur_end  = 0;
   int               last_end = 0;
   logic [WIDTH-1:0] pj = '0, pk = '0;
   logic [WIDTH-1:0] qs = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor/scoreboard: a command starts one cycle after it was accepted
   // and no earlier than the cycle after the previous command ended
   always @(negedge CLK) begin : mon
      logic [WIDTH-1:0] ej, ek;
      bit               ed, eb, emis;
      int               len;
      ej = '0;
      ek = '0;
      ed = 1'b0;
      emis = 1'b0;
      if (RST) begin
         pending.delete();
         active   = 1'b0;
         last_end = cyc;
         qs       = '0;
      end else begin
         emis = (q_in_val() != qs);
         for (int i = 0; i < WIDTH; i++) begin
            case ({pj[i], pk[i]})
               2'b10:   qs[i] = 1'b1;
               2'b01:   qs[i] = 1'b0;
               2'b11:   qs[i] = ~qs[i];
               default: qs[i] = qs[i];
            endcase
         end
         if (active && cyc > cur_end) begin
            active   = 1'b0;
            last_end = cur_end;
         end
         if (!active && pending.size() != 0) begin
            if (pending[0].acc < cyc && last_end < cyc) begin
               cur     = pending.pop_front();
               len     = (cur.op == OP_SET || cur.op == OP_CLEAR) ? 1 : cur.count + 1;
               active  = 1'b1;
               cur_end = cyc + len - 1;
            end
         end
         if (active) begin
            case (cur.op)
               OP_SET:    ej = cur.mask;
               OP_CLEAR:  ek = cur.mask;
               OP_TOGGLE: begin
                  ej = cur.mask;
                  ek = cur.mask;
               end
               default: ;
            endcase
            ed = (cyc == cur_end);
         end
      end
      eb = !RST && (active || pending.size() != 0);
      check("J", J, ej);
      check("K", K, ek);
      check("done", done, ed);
      check("busy", busy, eb);
`ifdef JKSEQ_SHADOW_EN
      check("q_shadow", q_shadow, qs);
      check("shadow_mismatch", shadow_mismatch, emis);
`endif
      pj = ej;
      pk = ek;
   end

   function automatic logic [WIDTH-1:0] q_in_val();
`ifdef JKSEQ_SHADOW_EN
      return q_in;
`else
      return qs;
`endif
   endfunction

   // One stimulus cycle: inputs set just after the falling edge, for the next rising edge
   task automatic drive(input bit rst, input bit valid, input int op,
                        input logic [WIDTH-1:0] mask, input int count);
      bit   exp_ready;
      cmd_s e;
      @(negedge CLK);
      #1;
      exp_ready = (pending.size() < DEPTH);
      check("cmd_ready", cmd_ready, exp_ready);
      RST       = rst;
      cmd_valid = valid;
      cmd_op    = op[1:0];
      cmd_mask  = mask;
      cmd_count = count[CNT_W-1:0];
`ifdef JKSEQ_SHADOW_EN
      q_in = ($urandom_range(0, 1) == 1) ? qs : WIDTH'($urandom);
`endif
      if (valid && exp_ready && !rst) begin
         e.op    = op;
         e.mask  = mask;
         e.count = count;
         e.acc   = cyc + 1;
         pending.push_back(e);
      end
   endtask

   task automatic idle_cycle();
      drive(1'b0, 1'b0, OP_HOLD, '0, 0);
   endtask

   task automatic wait_idle(input int max_cycles);
      int n = 0;
      while ((active || pending.size() != 0) && n < max_cycles) begin
         idle_cycle();
         n++;
      end
      idle_cycle();
      check("drain", (active || pending.size() != 0), 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset for two cycles; the command pushed meanwhile must be discarded
      drive(1'b1, 1'b1, OP_SET, 4'b1111, 0);
      drive(1'b1, 1'b0, OP_HOLD, '0, 0);
      idle_cycle();
      idle_cycle();

      drive(1'b0, 1'b1, OP_SET, 4'b0101, 0);
      wait_idle(10);

      drive(1'b0, 1'b1, OP_TOGGLE, 4'b0011, 3);
      wait_idle(20);

      drive(1'b0, 1'b1, OP_SET, 4'b1010, 0);
      drive(1'b0, 1'b1, OP_CLEAR, 4'b1111, 0);
      wait_idle(10);

      // Fill the FIFO behind a long HOLD; the fifth queued push is refused
      drive(1'b0, 1'b1, OP_HOLD, 4'b1111, 20);
      drive(1'b0, 1'b1, OP_TOGGLE, 4'b0110, 1);
      drive(1'b0, 1'b1, OP_SET, 4'b1001, 7);
      drive(1'b0, 1'b1, OP_CLEAR, 4'b0011, 0);
      drive(1'b0, 1'b1, OP_HOLD, 4'b0000, 0);
      drive(1'b0, 1'b1, OP_SET, 4'b1111, 0);
      wait_idle(100);

      // Longest run length and an empty mask
      drive(1'b0, 1'b1, OP_TOGGLE, 4'b1001, 255);
      wait_idle(300);
      drive(1'b0, 1'b1, OP_TOGGLE, 4'b0000, 2);
      wait_idle(10);

      // Reset during the third drive cycle of a long TOGGLE
      drive(1'b0, 1'b1, OP_TOGGLE, 4'b1111, 10);
      idle_cycle();
      idle_cycle();
      idle_cycle();
      drive(1'b1, 1'b0, OP_HOLD, '0, 0);
      idle_cycle();
      idle_cycle();
      check("post_reset_idle", (active || pending.size() != 0), 1'b0);

      // Random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         bit rst_i;
         int cnt_i;
         rst_i = ($urandom_range(0, 199) == 0);
         cnt_i = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 3));
         drive(rst_i, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)),
               WIDTH'($urandom), cnt_i);
      end
      wait_idle(1000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
